// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bus shared by the three writeback sources and the register-file arbiter.
// The arbiter takes the slave side; the sources (or a bench) drive the master side.
interface regfile_wr_arbiter_if #(
  parameter int DW = 16
);
  logic [2:0]    req;
  logic [2:0]    req_lock;
  logic [DW-1:0] req_data0;
  logic [DW-1:0] req_data1;
  logic [DW-1:0] req_data2;
  logic [2:0]    req_sel0;
  logic [2:0]    req_sel1;
  logic [2:0]    req_sel2;
  logic [2:0]    gnt;
  logic [DW-1:0] d;
  logic          load;
  logic [2:0]    wsel;
  logic          locked;
  logic          lock_timeout;

  modport slave (
    input  req, req_lock, req_data0, req_data1, req_data2,
    input  req_sel0, req_sel1, req_sel2,
    output gnt, d, load, wsel, locked, lock_timeout
  );

  modport master (
    output req, req_lock, req_data0, req_data1, req_data2,
    output req_sel0, req_sel1, req_sel2,
    input  gnt, d, load, wsel, locked, lock_timeout
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with burst locking
// and a forced release of locks that sit idle for LOCK_MAX cycles.
module regfile_wr_arbiter #(
  parameter int DW       = 16,
  parameter int LOCK_MAX = 15
) (
  input logic                CLK,
  input logic                RST,
  regfile_wr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;
  logic [7:0]    icnt_q, icnt_d;
  logic [DW-1:0] d_q, d_d;
  logic [2:0]    wsel_q, wsel_d;
  logic          load_q, load_d;
  logic          locked_q, locked_d;
  logic          tout_q, tout_d;

  logic [2:0]    gnt;
  logic          acc;
  logic [1:0]    acc_idx;
  logic [DW-1:0] acc_data;
  logic [2:0]    acc_sel;
  logic          acc_lock;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Scan from the lowest priority upward so the highest-priority requester overwrites.
  always_comb begin
    logic [1:0] idx;
    gnt = 3'b000;
    idx = 2'd0;
    if (!RST) begin
      if (state_q == LOCKED) begin
        gnt[owner_q] = bus.req[owner_q];
      end else begin
        for (int k = 2; k >= 0; k--) begin
          idx = wrap3({1'b0, ptr_q} + 3'(k));
          if (bus.req[idx]) begin
            gnt      = 3'b000;
            gnt[idx] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    acc      = |(gnt & bus.req);
    acc_idx  = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
    acc_data = bus.req_data0;
    acc_sel  = bus.req_sel0;
    if (acc_idx == 2'd1) begin
      acc_data = bus.req_data1;
      acc_sel  = bus.req_sel1;
    end else if (acc_idx == 2'd2) begin
      acc_data = bus.req_data2;
      acc_sel  = bus.req_sel2;
    end
    acc_lock = bus.req_lock[acc_idx];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    icnt_d  = icnt_q;
    d_d     = d_q;
    wsel_d  = wsel_q;
    load_d  = 1'b0;
    tout_d  = 1'b0;

    if (acc) begin
      d_d    = acc_data;
      wsel_d = acc_sel;
      load_d = 1'b1;
      ptr_d  = wrap3({1'b0, acc_idx} + 3'd1);
    end

    unique case (state_q)
      IDLE: begin
        if (acc && acc_lock) begin
          state_d = LOCKED;
          owner_d = acc_idx;
          icnt_d  = 8'd0;
        end
      end
      LOCKED: begin
        if (acc) begin
          icnt_d = 8'd0;
          if (!acc_lock) state_d = IDLE;
        end else if (icnt_q == 8'(LOCK_MAX - 1)) begin
          state_d = IDLE;
          tout_d  = 1'b1;
          icnt_d  = 8'd0;
          ptr_d   = wrap3({1'b0, owner_q} + 3'd1);
        end else begin
          icnt_d = icnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      icnt_q   <= 8'd0;
      d_q      <= '0;
      wsel_q   <= 3'd0;
      load_q   <= 1'b0;
      locked_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      icnt_q   <= icnt_d;
      d_q      <= d_d;
      wsel_q   <= wsel_d;
      load_q   <= load_d;
      locked_q <= locked_d;
      tout_q   <= tout_d;
    end
  end

  assign bus.gnt          = gnt;
  assign bus.d            = d_q;
  assign bus.load         = load_q;
  assign bus.wsel         = wsel_q;
  assign bus.locked       = locked_q;
  assign bus.lock_timeout = tout_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter: a per-cycle reference model feeds
// expected writes and status into queues that an independent monitor drains.
module tb_regfile_wr_arbiter;
  localparam int DW       = 16;
  localparam int LOCK_MAX = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  regfile_wr_arbiter_if #(.DW(DW)) bus ();

  regfile_wr_arbiter #(.DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [2:0]    wsel;
  } wr_t;

  typedef struct packed {
    logic          load;
    logic          locked;
    logic          tout;
    logic [DW-1:0] d;
    logic [2:0]    wsel;
  } st_t;

  wr_t wq[$];
  st_t sq[$];

  int total = 0;
  int bad   = 0;

  logic          drv_rst;
  logic [2:0]    drv_req;
  logic [2:0]    drv_lock;
  logic [DW-1:0] drv_data [3];
  logic [2:0]    drv_sel  [3];
  int            last_acc;

  int            m_ptr, m_owner, m_icnt;
  bit            m_locked;
  logic [DW-1:0] m_d;
  logic [2:0]    m_wsel;

  function automatic logic [2:0] model_gnt();
    logic [2:0] g = 3'b000;
    if (drv_rst) return g;
    if (m_locked) begin
      g[m_owner] = drv_req[m_owner];
      return g;
    end
    for (int k = 0; k < 3; k++) begin
      int i = (m_ptr + k) % 3;
      if (drv_req[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic cycle();
    logic [2:0] g;
    int a;
    st_t s;
    @(negedge CLK);
    RST           = drv_rst;
    bus.req       = drv_req;
    bus.req_lock  = drv_lock;
    bus.req_data0 = drv_data[0];
    bus.req_data1 = drv_data[1];
    bus.req_data2 = drv_data[2];
    bus.req_sel0  = drv_sel[0];
    bus.req_sel1  = drv_sel[1];
    bus.req_sel2  = drv_sel[2];
    #1;
    g = model_gnt();
    total++;
    if (bus.gnt !== g) begin
      bad++;
      $display("FAIL gnt t=%0t got=%b exp=%b req=%b", $time, bus.gnt, g, drv_req);
    end
    a = -1;
    for (int i = 0; i < 3; i++) if (g[i] && drv_req[i]) a = i;
    s = '0;
    if (drv_rst) begin
      m_ptr = 0; m_owner = 0; m_icnt = 0; m_locked = 0;
      m_d = '0; m_wsel = '0;
      a = -1;
    end else if (a >= 0) begin
      m_d    = drv_data[a];
      m_wsel = drv_sel[a];
      wq.push_back('{d: m_d, wsel: m_wsel});
      m_ptr  = (a + 1) % 3;
      if (!m_locked) begin
        if (drv_lock[a]) begin
          m_locked = 1; m_owner = a; m_icnt = 0;
        end
      end else if (drv_lock[a]) begin
        m_icnt = 0;
      end else begin
        m_locked = 0;
      end
    end else if (m_locked) begin
      if (m_icnt == LOCK_MAX - 1) begin
        m_locked = 0; s.tout = 1; m_icnt = 0; m_ptr = (m_owner + 1) % 3;
      end else begin
        m_icnt++;
      end
    end
    s.load   = (a >= 0);
    s.locked = m_locked;
    s.d      = m_d;
    s.wsel   = m_wsel;
    sq.push_back(s);
    last_acc = a;
  endtask

  // Monitor: outputs registered at the previous rising edge are stable on the falling edge.
  initial begin
    st_t s;
    wr_t w;
    forever begin
      @(negedge CLK);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        total++;
        if ({bus.load, bus.locked, bus.lock_timeout} !== {s.load, s.locked, s.tout}) begin
          bad++;
          $display("FAIL status t=%0t got load/locked/tout=%b%b%b exp=%b%b%b", $time,
                   bus.load, bus.locked, bus.lock_timeout, s.load, s.locked, s.tout);
        end
        total++;
        if ({bus.d, bus.wsel} !== {s.d, s.wsel}) begin
          bad++;
          $display("FAIL hold t=%0t got d=%h wsel=%0d exp d=%h wsel=%0d", $time,
                   bus.d, bus.wsel, s.d, s.wsel);
        end
      end
      if (bus.load === 1'b1) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL write t=%0t unexpected write d=%h wsel=%0d", $time, bus.d, bus.wsel);
        end else begin
          w = wq.pop_front();
          if ({bus.d, bus.wsel} !== {w.d, w.wsel}) begin
            bad++;
            $display("FAIL write t=%0t got d=%h wsel=%0d exp d=%h wsel=%0d", $time,
                     bus.d, bus.wsel, w.d, w.wsel);
          end
        end
      end
    end
  end

  task automatic set(input logic r, input logic [2:0] q, input logic [2:0] lk, input int n);
    drv_rst = r; drv_req = q; drv_lock = lk;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    drv_rst = 1; drv_req = 0; drv_lock = 0;
    drv_data[0] = 16'h1111; drv_data[1] = 16'h2222; drv_data[2] = 16'h3333;
    drv_sel[0]  = 3'd1;     drv_sel[1]  = 3'd2;     drv_sel[2]  = 3'd3;
    m_ptr = 0; m_owner = 0; m_icnt = 0; m_locked = 0; m_d = '0; m_wsel = '0;

    set(1, 3'b111, 3'b000, 2);   // reset with all requests up
    set(0, 3'b111, 3'b000, 6);   // round-robin rotation
    set(0, 3'b000, 3'b000, 2);
    drv_sel[2] = 3'd7; drv_data[2] = 16'hBEEF;
    set(0, 3'b100, 3'b000, 1);   // single requester
    set(0, 3'b000, 3'b000, 2);
    set(0, 3'b001, 3'b000, 1);   // moves pointer to requester 1
    set(0, 3'b011, 3'b010, 2);   // locked burst from requester 1
    set(0, 3'b011, 3'b000, 1);
    set(0, 3'b001, 3'b000, 1);
    set(0, 3'b100, 3'b100, 1);   // lock then idle until timeout
    set(0, 3'b001, 3'b000, 7);
    set(0, 3'b000, 3'b000, 1);
    set(0, 3'b100, 3'b100, 1);   // reset in the middle of a lock
    set(1, 3'b100, 3'b100, 1);
    set(0, 3'b111, 3'b000, 2);

    for (int n = 0; n < 500; n++) begin
      logic [2:0] nreq, nlk;
      nreq = 3'b000; nlk = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (drv_req[i] && last_acc != i && !drv_rst && $urandom_range(9) != 0) begin
          nreq[i] = 1'b1;
          nlk[i]  = drv_lock[i];
        end else begin
          nreq[i]     = ($urandom_range(1) == 1);
          nlk[i]      = ($urandom_range(9) < 3);
          drv_data[i] = DW'($urandom);
          drv_sel[i]  = 3'($urandom);
        end
      end
      set(($urandom_range(99) == 0), nreq, nlk, 1);
    end

    set(0, 3'b000, 3'b000, 3);
    @(negedge CLK);
    total++;
    if (wq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", wq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
